// File: rtl/bist_control_reg.sv
// JTAG serial-in/parallel-out BIST control register: LSB-first shift, length check, VALID pulse.
// Define BIST_CTRL_PARITY_EN to append an odd-parity frame bit and expose the PAR_ERR output.
module bist_control_reg #(
   parameter int unsigned      WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             TCK,
   input  logic             TRST,
   input  logic             ENABLE,
   input  logic             CAPTURE,
   input  logic             SHIFT,
   input  logic             UPDATE,
   input  logic             TDI,
   output logic             TDO,
   output logic [WIDTH-1:0] CONTROL_REG,
   output logic             VALID,
`ifdef BIST_CTRL_PARITY_EN
   output logic             PAR_ERR,
`endif
   output logic             LEN_ERR
);

`ifdef BIST_CTRL_PARITY_EN
   localparam int unsigned SW = WIDTH + 1;
`else
   localparam int unsigned SW = WIDTH;
`endif
   localparam int unsigned   CW       = $clog2(SW + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(SW);
   localparam logic [CW-1:0] CNT_OVER = CW'(SW + 1);

   typedef enum logic [1:0] {IDLE, LOADED, SHIFTING, OVERRUN} state_e;

   state_e           state_q, state_d;
   logic [SW-1:0]    shreg_q, shreg_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] control_q, control_d;
   logic             tdo_q, tdo_d;
   logic             valid_q, valid_d;
   logic             len_err_q, len_err_d;
   logic             frame_ok;
   logic [SW-1:0]    readback;

`ifdef BIST_CTRL_PARITY_EN
   logic par_err_q, par_err_d;
   // Odd parity: data plus parity bit must hold an odd number of ones.
   assign frame_ok = ^shreg_q;
   assign readback = {~^control_q, control_q};
`else
   assign frame_ok = 1'b1;
   assign readback = control_q;
`endif

   always_comb begin
      // NOTE: every _d starts from its hold value so no branch can infer a latch.
      state_d   = state_q;
      shreg_d   = shreg_q;
      count_d   = count_q;
      control_d = control_q;
      tdo_d     = tdo_q;
      valid_d   = 1'b0;
      len_err_d = len_err_q;
`ifdef BIST_CTRL_PARITY_EN
      par_err_d = par_err_q;
`endif
      if (!ENABLE) begin
         count_d = '0;
         state_d = IDLE;
      end else if (CAPTURE) begin
         shreg_d   = readback;
         count_d   = '0;
         len_err_d = 1'b0;
`ifdef BIST_CTRL_PARITY_EN
         par_err_d = 1'b0;
`endif
         state_d   = LOADED;
      end else if (SHIFT) begin
         tdo_d   = shreg_q[0];
         shreg_d = {TDI, shreg_q[SW-1:1]};
         // Count saturates once OVERRUN is reached, so it can never wrap.
         if (state_q != OVERRUN) count_d = count_q + CW'(1);
         state_d = (count_d == CNT_OVER) ? OVERRUN : SHIFTING;
      end else if (UPDATE) begin
         count_d = '0;
         state_d = IDLE;
         if (count_q == CNT_FULL) begin
            len_err_d = 1'b0;
            if (frame_ok) begin
               control_d = shreg_q[WIDTH-1:0];
               valid_d   = 1'b1;
            end
`ifdef BIST_CTRL_PARITY_EN
            else begin
               par_err_d = 1'b1;
            end
`endif
         end else begin
            len_err_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         count_q   <= '0;
         control_q <= RESET_VALUE;
         tdo_q     <= 1'b0;
         valid_q   <= 1'b0;
         len_err_q <= 1'b0;
`ifdef BIST_CTRL_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         count_q   <= count_d;
         control_q <= control_d;
         tdo_q     <= tdo_d;
         valid_q   <= valid_d;
         len_err_q <= len_err_d;
`ifdef BIST_CTRL_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   assign TDO         = tdo_q;
   assign CONTROL_REG = control_q;
   assign VALID       = valid_q;
   assign LEN_ERR     = len_err_q;
`ifdef BIST_CTRL_PARITY_EN
   assign PAR_ERR     = par_err_q;
`endif

endmodule
